ppu_writer: RTL and testbench
=============================

PPU_WRITER -- requirements
Module: ppu_writer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, command FIFO entries (power of two, 2..64).
REQ-002 SHALL have parameter MAX_WRITES, default 64, maximum bus writes issued per vertical blank.
REQ-003 SHALL have port clk  input  1  single clock for all logic.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-005 SHALL have port cmd_valid  input  1  command present.
REQ-006 SHALL have port cmd_ready  output  1  command accepted when cmd_valid and cmd_ready are both high at a rising edge.
REQ-007 SHALL have port cmd_region  input  2  target table: 0 attribute, 1 sprite, 2 color, 3 illegal.
REQ-008 SHALL have port cmd_index  input  8  table entry index.
REQ-009 SHALL have port cmd_data  input  32  word to write.
REQ-010 SHALL have port vcount  input  10  current display line from the VGA counters.
REQ-011 SHALL have ports chipselect and write  output  1 each  PPU bus strobes.
REQ-012 SHALL have port address  output  16  PPU bus address.
REQ-013 SHALL have port writedata  output  32  PPU bus data.
REQ-014 SHALL have port busy  output  1  high while the FIFO is non-empty or a write is on the bus.
REQ-015 SHALL have port err_bad_cmd  output  1  sticky illegal-command flag.

Function
REQ-016 SHALL set cmd_ready = !full, combinational from the FIFO occupancy count.
REQ-017 SHALL validate a command at acceptance: region 3, or region 0/2 with cmd_index[7:4] != 0, is illegal; it is discarded, not stored, and sets err_bad_cmd.
REQ-018 SHALL store each legal command as {region, index, data} in the FIFO in arrival order.
REQ-019 SHALL implement states IDLE and BURST; IDLE -> BURST when 480 <= vcount <= 524; BURST -> IDLE when vcount < 480.
REQ-020 SHALL reset the per-frame write counter to 0 on every IDLE -> BURST transition.
REQ-021 SHALL, in BURST with the FIFO non-empty and the counter < MAX_WRITES, pop one entry per cycle and increment the counter.
REQ-022 SHALL register all bus outputs: for an entry popped at edge t, chipselect = write = 1 for exactly the one cycle after edge t, address = {6'b0, region, index}, writedata = data.
REQ-023 SHALL drive chipselect = write = 0, and hold address/writedata at their last values, in every cycle with no pop.
REQ-024 SHALL allow back-to-back writes on consecutive cycles.
REQ-025 SHALL allow push and pop in the same cycle; occupancy is then unchanged.
REQ-026 SHALL deliver a command accepted at edge t into an empty FIFO during BURST to the bus no earlier than the cycle after edge t+1.
REQ-027 SHALL leave un-issued entries in the FIFO when BURST ends or MAX_WRITES is reached; they are issued in the next vertical blank.
REQ-028 SHALL let a pop already committed at the edge where vcount leaves blank complete its one-cycle write.
REQ-029 SHALL wrap FIFO pointers modulo FIFO_DEPTH and hold the occupancy count in range 0..FIFO_DEPTH.

Reset
REQ-030 SHALL, while reset is low at a rising edge, set state IDLE, FIFO empty, write counter 0, chipselect = write = 0, address = 0, writedata = 0, and err_bad_cmd = 0.
REQ-031 SHALL drive cmd_ready = 1 and busy = 0 in the cycle after reset; commands pending before a mid-operation reset are lost.

Verification
REQ-032 SHALL pass: vcount = 100, push region 0/index 3/data 0xA5A5_0001 -> no bus write; vcount = 480 -> one write, address 0x0003, writedata 0xA5A5_0001.
REQ-033 SHALL pass: push 8 commands with vcount = 200 -> cmd_ready = 0 after the 8th; at vcount = 480 -> 8 consecutive one-cycle writes in order, then busy = 0.
REQ-034 SHALL pass: MAX_WRITES = 4 with 6 commands queued -> 4 writes in the first blank, 2 in the next.
REQ-035 SHALL pass: region 3, or region 2 with index 0x12 -> nothing stored, err_bad_cmd = 1 until reset; the following legal region 1/index 0xFF command -> address 0x01FF.
REQ-036 SHALL pass: vcount 524 -> 0 with 3 entries queued -> writing stops, remainder kept; reset low mid-burst -> all outputs 0 and FIFO empty next cycle.

Source files
------------

// File: rtl/ppu_writer.sv
// ppu_writer: buffers PPU table writes in a small command FIFO and drains
// them onto the PPU bus only during vertical blank, at most MAX_WRITES
// writes per blank, one per cycle.
module ppu_writer #(
    parameter int FIFO_DEPTH = 8,
    parameter int MAX_WRITES = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_region,
    input  logic [7:0]  cmd_index,
    input  logic [31:0] cmd_data,
    input  logic [9:0]  vcount,
    output logic        chipselect,
    output logic        write,
    output logic [15:0] address,
    output logic [31:0] writedata,
    output logic        busy,
    output logic        err_bad_cmd
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(MAX_WRITES + 1);
    localparam int EW = 42;  // {region[1:0], index[7:0], data[31:0]}

    typedef enum logic {IDLE, BURST} state_t;

    state_t          state_reg;
    logic [EW-1:0]   mem [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr_reg;
    logic [PW-1:0]   rd_ptr_reg;
    logic [PW:0]     count_reg;
    logic [CW-1:0]   wcnt_reg;

    logic accept;
    logic illegal;
    logic push;
    logic pop;
    logic in_blank;
    logic fifo_full;
    logic fifo_empty;

    // Occupancy flags, command validation and the per-cycle pop decision.
    always_comb begin
        fifo_full  = (count_reg == (PW+1)'(FIFO_DEPTH));
        fifo_empty = (count_reg == '0);
        cmd_ready  = !fifo_full;
        accept     = cmd_valid && !fifo_full;
        // Attribute and color tables only have 16 entries; sprite has 256.
        illegal    = (cmd_region == 2'd3) ||
                     ((cmd_region != 2'd1) && (cmd_index[7:4] != 4'd0));
        push       = accept && !illegal;
        pop        = (state_reg == BURST) && !fifo_empty &&
                     (wcnt_reg < CW'(MAX_WRITES));
        in_blank   = (vcount >= 10'd480) && (vcount <= 10'd524);
        busy       = !fifo_empty || chipselect;
    end

    // Command storage: plain array written on push, read by the bus register.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= {cmd_region, cmd_index, cmd_data};
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally (power-of-two depth).
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
            case ({push, pop})
                2'b10:   count_reg <= count_reg + (PW+1)'(1);
                2'b01:   count_reg <= count_reg - (PW+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Blank-tracking FSM, per-frame write budget and registered bus outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg  <= IDLE;
            wcnt_reg   <= '0;
            chipselect <= 1'b0;
            write      <= 1'b0;
            address    <= '0;
            writedata  <= '0;
        end else begin
            chipselect <= pop;
            write      <= pop;
            if (pop) begin
                address   <= {6'b0, mem[rd_ptr_reg][41:32]};
                writedata <= mem[rd_ptr_reg][31:0];
                wcnt_reg  <= wcnt_reg + CW'(1);
            end
            case (state_reg)
                IDLE: begin
                    if (in_blank) begin
                        state_reg <= BURST;
                        wcnt_reg  <= '0;
                    end
                end
                BURST: begin
                    // A pop decided at this edge still completes its write.
                    if (vcount < 10'd480) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Sticky illegal-command flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            err_bad_cmd <= 1'b0;
        end else if (accept && illegal) begin
            err_bad_cmd <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ppu_writer.sv
// tb_ppu_writer: drives two ppu_writer instances (default budget and a
// budget of 4) with the same directed stimulus, compares both against a
// queue-based model every cycle, and pins key results with literal checks.
module tb_ppu_writer;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic [1:0]  cmd_region;
    logic [7:0]  cmd_index;
    logic [31:0] cmd_data;
    logic [9:0]  vcount;

    logic        ready0, cs0, wr0, busy0, err0;
    logic [15:0] addr0;
    logic [31:0] data0;
    logic        ready1, cs1, wr1, busy1, err1;
    logic [15:0] addr1;
    logic [31:0] data1;

    int total  = 0;
    int passed = 0;
    bit check_en = 1'b0;

    always #5 clk = ~clk;

    ppu_writer #(.FIFO_DEPTH(8), .MAX_WRITES(64)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(ready0),
        .cmd_region(cmd_region), .cmd_index(cmd_index), .cmd_data(cmd_data),
        .vcount(vcount), .chipselect(cs0), .write(wr0), .address(addr0),
        .writedata(data0), .busy(busy0), .err_bad_cmd(err0)
    );

    ppu_writer #(.FIFO_DEPTH(8), .MAX_WRITES(4)) dut4 (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(ready1),
        .cmd_region(cmd_region), .cmd_index(cmd_index), .cmd_data(cmd_data),
        .vcount(vcount), .chipselect(cs1), .write(wr1), .address(addr1),
        .writedata(data1), .busy(busy1), .err_bad_cmd(err1)
    );

    // ---------------- behavioural model ----------------
    logic [41:0] mq [2][$];
    int          mcnt   [2];
    bit          mburst [2];
    bit          mcs    [2];
    logic [15:0] maddr  [2];
    logic [31:0] mdata  [2];
    bit          merr   [2];

    function automatic int budget(input int m);
        return (m == 0) ? 64 : 4;
    endfunction

    always @(posedge clk) begin
        bit          legal;
        bit          take;
        logic [41:0] e;
        for (int m = 0; m < 2; m++) begin
            if (!reset) begin
                mq[m].delete();
                mcnt[m] = 0; mburst[m] = 0; mcs[m] = 0;
                maddr[m] = 16'h0; mdata[m] = 32'h0; merr[m] = 0;
            end else begin
                take  = cmd_valid && (mq[m].size() < 8);
                legal = !(cmd_region == 2'd3 ||
                          ((cmd_region == 2'd0 || cmd_region == 2'd2) && cmd_index >= 8'd16));
                // Pop is judged on the contents before this edge's push.
                if (mburst[m] && mq[m].size() > 0 && mcnt[m] < budget(m)) begin
                    e = mq[m].pop_front();
                    mcs[m]   = 1;
                    maddr[m] = {6'b0, e[41:32]};
                    mdata[m] = e[31:0];
                    mcnt[m]++;
                end else begin
                    mcs[m] = 0;
                end
                if (take && legal)  mq[m].push_back({cmd_region, cmd_index, cmd_data});
                if (take && !legal) merr[m] = 1;
                if (!mburst[m] && vcount >= 480 && vcount <= 524) begin
                    mburst[m] = 1;
                    mcnt[m]   = 0;
                end else if (mburst[m] && vcount < 480) begin
                    mburst[m] = 0;
                end
            end
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic cmp(input int m, input logic cs, input logic wr, input logic [15:0] a,
                       input logic [31:0] d, input logic rdy, input logic bsy, input logic er);
        string p;
        p = (m == 0) ? "dut" : "dut4";
        chk({p, ".chipselect"}, cs, mcs[m]);
        chk({p, ".write"}, wr, mcs[m]);
        chk({p, ".address"}, a, maddr[m]);
        chk({p, ".writedata"}, d, mdata[m]);
        chk({p, ".cmd_ready"}, rdy, mq[m].size() < 8);
        chk({p, ".busy"}, bsy, (mq[m].size() > 0) || mcs[m]);
        chk({p, ".err_bad_cmd"}, er, merr[m]);
    endtask

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (check_en) begin
            cmp(0, cs0, wr0, addr0, data0, ready0, busy0, err0);
            cmp(1, cs1, wr1, addr1, data1, ready1, busy1, err1);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input logic [1:0] r, input logic [7:0] i, input logic [31:0] d);
        cmd_valid = 1'b1; cmd_region = r; cmd_index = i; cmd_data = d;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_cs(input string name);
        int n;
        n = 0;
        while (!cs0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk(name, cs0, 1'b1);
    endtask

    initial begin
        int n0, n1;
        reset = 1'b0; cmd_valid = 1'b0; cmd_region = 2'd0; cmd_index = 8'd0;
        cmd_data = 32'd0; vcount = 10'd0;
        tick(2);
        check_en = 1'b1;
        reset = 1'b1;
        chk("reset cmd_ready", ready0, 1'b1);
        chk("reset busy", busy0, 1'b0);
        chk("reset chipselect", cs0, 1'b0);
        chk("reset address", addr0, 16'h0);
        chk("reset err", err0, 1'b0);

        // Single command held until blank.
        vcount = 10'd100;
        push(2'd0, 8'd3, 32'hA5A5_0001);
        tick(3);
        chk("no write outside blank", cs0, 1'b0);
        chk("busy while queued", busy0, 1'b1);
        vcount = 10'd480;
        wait_cs("first write seen");
        chk("first address", addr0, 16'h0003);
        chk("first writedata", data0, 32'hA5A5_0001);
        vcount = 10'd0;
        tick(3);

        // Fill the FIFO, then drain back-to-back.
        vcount = 10'd200;
        for (int i = 0; i < 8; i++) push(2'd1, 8'(i), 32'h1000_0000 + i);
        chk("full cmd_ready", ready0, 1'b0);
        vcount = 10'd480;
        wait_cs("burst start seen");
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("burst cs %0d", i), cs0, 1'b1);
            chk($sformatf("burst addr %0d", i), addr0, 16'h0100 + 16'(i));
            chk($sformatf("burst data %0d", i), data0, 32'h1000_0000 + i);
            @(negedge clk);
        end
        chk("burst end cs", cs0, 1'b0);
        chk("burst end busy", busy0, 1'b0);
        vcount = 10'd0;
        tick(2);
        vcount = 10'd480;   // lets the budget-4 instance drain its leftovers
        tick(10);
        vcount = 10'd0;
        tick(2);

        // Write budget: 6 queued, budget 4 issues 4 then 2.
        vcount = 10'd200;
        for (int i = 0; i < 6; i++) push(2'd2, 8'(i), 32'hC000_0000 + i);
        vcount = 10'd480;
        n0 = 0; n1 = 0;
        repeat (12) begin
            @(negedge clk);
            n0 += int'(cs0); n1 += int'(cs1);
        end
        chk("budget64 writes", n0, 6);
        chk("budget4 first blank", n1, 4);
        vcount = 10'd0;
        tick(2);
        vcount = 10'd480;
        n1 = 0;
        repeat (8) begin
            @(negedge clk);
            n1 += int'(cs1);
        end
        chk("budget4 second blank", n1, 2);
        vcount = 10'd0;
        tick(2);

        // Illegal commands are discarded and flagged.
        push(2'd3, 8'd0, 32'hDEAD_0000);
        push(2'd2, 8'h12, 32'hDEAD_0001);
        chk("err set", err0, 1'b1);
        chk("illegal not stored", busy0, 1'b0);
        push(2'd1, 8'hFF, 32'h1234_5678);
        vcount = 10'd480;
        wait_cs("sprite write seen");
        chk("sprite address", addr0, 16'h01FF);
        chk("sprite data", data0, 32'h1234_5678);
        chk("err sticky", err0, 1'b1);
        vcount = 10'd0;
        tick(2);

        // Blank ends with entries queued: committed pop completes, rest kept.
        vcount = 10'd200;
        for (int i = 1; i <= 3; i++) push(2'd0, 8'(i), 32'hB000_0000 + i);
        vcount = 10'd524;
        wait_cs("late blank write seen");
        vcount = 10'd0;
        n0 = 0;
        repeat (5) begin
            @(negedge clk);
            n0 += int'(cs0);
        end
        chk("one committed write after blank", n0, 1);
        chk("remainder kept", busy0, 1'b1);

        // Mid-burst reset clears everything.
        vcount = 10'd200;
        for (int i = 4; i <= 6; i++) push(2'd0, 8'(i), 32'hB000_0000 + i);
        vcount = 10'd480;
        wait_cs("pre-reset write seen");
        reset = 1'b0;
        @(negedge clk);
        chk("rst chipselect", cs0, 1'b0);
        chk("rst address", addr0, 16'h0);
        chk("rst writedata", data0, 32'h0);
        chk("rst busy", busy0, 1'b0);
        chk("rst cmd_ready", ready0, 1'b1);
        chk("rst err", err0, 1'b0);
        reset = 1'b1;
        n0 = 0;
        repeat (6) begin
            @(negedge clk);
            n0 += int'(cs0);
        end
        chk("no writes after reset", n0, 0);
        vcount = 10'd0;
        tick(2);

        check_en = 1'b0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
